// File: rtl/leaf_out_if.sv
// leaf_out_if: user stream, configuration, credit return and BFT packet bundle.
// The slave modport faces leaf_out_arbiter; the master modport faces its driver.
interface leaf_out_if #(
  parameter int NUM_OUT_PORTS = 3,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int CREDIT_BITS   = 8,
  parameter int PACKET_BITS   = 49
) ();
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic                                  cfg_wr;
  logic [NUM_PORT_BITS-1:0]              cfg_port;
  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf;
  logic [NUM_PORT_BITS-1:0]              cfg_dest_port;
  logic [CREDIT_BITS-1:0]                cfg_credit;
  logic                                  credit_ret_vld;
  logic [NUM_PORT_BITS-1:0]              credit_ret_port;
  logic [CREDIT_BITS-1:0]                credit_ret_amt;
  logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;
  logic                                  bft_ack;
  logic                                  resend;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user,
    output cfg_wr,
    output cfg_port,
    output cfg_dest_leaf,
    output cfg_dest_port,
    output cfg_credit,
    output credit_ret_vld,
    output credit_ret_port,
    output credit_ret_amt,
    input  dout_leaf_interface2bft,
    output bft_ack,
    output resend
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user,
    input  cfg_wr,
    input  cfg_port,
    input  cfg_dest_leaf,
    input  cfg_dest_port,
    input  cfg_credit,
    input  credit_ret_vld,
    input  credit_ret_port,
    input  credit_ret_amt,
    output dout_leaf_interface2bft,
    input  bft_ack,
    input  resend
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: per-port FIFOs, credit-gated round-robin, one BFT packet/cycle.
// Optional LEAF_OUT_PKT_COUNT_EN adds per-port acknowledged-packet counters.
module leaf_out_arbiter #(
  parameter int NUM_OUT_PORTS = 3,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 49,
  parameter int FIFO_DEPTH    = 4,
  parameter int CREDIT_BITS   = 8
) (
  input logic clk,
  input logic reset_n,
  leaf_out_if.slave bus
`ifdef LEAF_OUT_PKT_COUNT_EN
  ,
  output logic [NUM_OUT_PORTS*16-1:0] pkt_count
`endif
);
  localparam int N  = NUM_OUT_PORTS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PB = PAYLOAD_BITS;
  localparam int CB = CREDIT_BITS;

  logic [PB-1:0]            mem_q [N][FIFO_DEPTH];
  logic [PB-1:0]            mem_d [N][FIFO_DEPTH];
  logic [AW:0]              wr_ptr_q [N];
  logic [AW:0]              wr_ptr_d [N];
  logic [AW:0]              rd_ptr_q [N];
  logic [AW:0]              rd_ptr_d [N];
  logic [CB-1:0]            credit_q [N];
  logic [CB-1:0]            credit_d [N];
  logic [NUM_ADDR_BITS-1:0] seq_q [N];
  logic [NUM_ADDR_BITS-1:0] seq_d [N];
  logic [NUM_LEAF_BITS-1:0] dleaf_q [N];
  logic [NUM_LEAF_BITS-1:0] dleaf_d [N];
  logic [NUM_PORT_BITS-1:0] dport_q [N];
  logic [NUM_PORT_BITS-1:0] dport_d [N];
  logic [IW-1:0]            last_q, last_d;
  logic [PACKET_BITS-1:0]   out_q, out_d;

  logic [N-1:0] full, empty, elig, push;
  logic [IW-1:0] gnt;
  logic gnt_vld, issue_ok, issue;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      full[i]  = (wr_ptr_q[i] - rd_ptr_q[i]) == (AW+1)'(FIFO_DEPTH);
      empty[i] = wr_ptr_q[i] == rd_ptr_q[i];
      elig[i]  = !empty[i] && (credit_q[i] != '0);
      push[i]  = bus.vld_user2interface[i] && !full[i];
    end
  end

  assign bus.ack_interface2user = push;

  // Search starts one past the last grant, so reset (last = N-1) favours port 0.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && elig[idx]) begin
        gnt     = IW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  assign issue_ok = !bus.resend && (!out_q[PACKET_BITS-1] || bus.bft_ack);
  assign issue    = issue_ok && gnt_vld;

  always_comb begin
    out_d  = out_q;
    last_d = last_q;
    if (issue) begin
      out_d  = {1'b1, dleaf_q[gnt], dport_q[gnt], seq_q[gnt],
                mem_q[gnt][rd_ptr_q[gnt][AW-1:0]]};
      last_d = gnt;
    end else if (issue_ok) begin
      out_d = '0;
    end
  end

  always_comb begin
    logic          pop;
    logic [CB:0]   csum;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    credit_d = credit_q;
    seq_d    = seq_q;
    dleaf_d  = dleaf_q;
    dport_d  = dport_q;
    pop      = 1'b0;
    csum     = '0;
    for (int i = 0; i < N; i++) begin
      pop = issue && (gnt == IW'(i));
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i][AW-1:0]] =
          bus.din_leaf_user2interface[i*PB +: PB];
        wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      end
      if (pop) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
        seq_d[i]    = seq_q[i] + 1'b1;
      end
      csum = {1'b0, credit_q[i]} - {{CB{1'b0}}, pop};
      if (bus.credit_ret_vld &&
          bus.credit_ret_port == NUM_PORT_BITS'(i))
        csum = csum + {1'b0, bus.credit_ret_amt};
      credit_d[i] = csum[CB] ? {CB{1'b1}} : csum[CB-1:0];
      if (bus.cfg_wr && bus.cfg_port == NUM_PORT_BITS'(i)) begin
        dleaf_d[i]  = bus.cfg_dest_leaf;
        dport_d[i]  = bus.cfg_dest_port;
        credit_d[i] = bus.cfg_credit;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        credit_q[i] <= '0;
        seq_q[i]    <= '0;
        dleaf_q[i]  <= '0;
        dport_q[i]  <= '0;
      end
      last_q <= IW'(N - 1);
      out_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      credit_q <= credit_d;
      seq_q    <= seq_d;
      dleaf_q  <= dleaf_d;
      dport_q  <= dport_d;
      last_q   <= last_d;
      out_q    <= out_d;
    end
  end

  // The held packet stays in out_q; resend only blanks what the BFT sees.
  assign bus.dout_leaf_interface2bft = bus.resend ? '0 : out_q;

`ifdef LEAF_OUT_PKT_COUNT_EN
  logic [IW-1:0] src_q, src_d;
  logic [15:0]   cnt_q [N];
  logic [15:0]   cnt_d [N];

  always_comb begin
    src_d = issue ? gnt : src_q;
    cnt_d = cnt_q;
    if (out_q[PACKET_BITS-1] && bus.bft_ack && !bus.resend)
      cnt_d[src_q] = cnt_q[src_q] + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      src_q <= src_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < N; i++) pkt_count[i*16 +: 16] = cnt_q[i];
  end
`endif
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: directed scenarios with hand-computed packets.
// Each task drives one scenario and compares dout/ack inline.
module tb_leaf_out_arbiter;
  localparam int N  = 3;
  localparam int PB = 49;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leaf_out_if #(
    .NUM_OUT_PORTS(N), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5),
    .NUM_PORT_BITS(4), .CREDIT_BITS(8), .PACKET_BITS(PB)
  ) bus ();

`ifdef LEAF_OUT_PKT_COUNT_EN
  logic [N*16-1:0] pkt_count;
`endif

  leaf_out_arbiter dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
`ifdef LEAF_OUT_PKT_COUNT_EN
    ,
    .pkt_count(pkt_count)
`endif
  );

  function automatic logic [PB-1:0] pkt(input logic [4:0] l,
    input logic [3:0] p, input logic [6:0] s, input logic [31:0] d);
    return {1'b1, l, p, s, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.din_leaf_user2interface = '0;
    bus.vld_user2interface = '0;
    bus.cfg_wr = 1'b0;
    bus.cfg_port = '0;
    bus.cfg_dest_leaf = '0;
    bus.cfg_dest_port = '0;
    bus.cfg_credit = '0;
    bus.credit_ret_vld = 1'b0;
    bus.credit_ret_port = '0;
    bus.credit_ret_amt = '0;
    bus.bft_ack = 1'b0;
    bus.resend = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic cfg(input int port, input logic [4:0] l,
    input logic [3:0] p, input logic [7:0] c);
    bus.cfg_wr = 1'b1;
    bus.cfg_port = 4'(port);
    bus.cfg_dest_leaf = l;
    bus.cfg_dest_port = p;
    bus.cfg_credit = c;
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic set_din(input int port, input logic [31:0] d);
    bus.din_leaf_user2interface[port*32 +: 32] = d;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #3;
    checks++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      errors++;
      $display("FAIL reset_dout: got %h want 0", bus.dout_leaf_interface2bft);
    end
    tick();
    reset_n = 1'b1;
    tick();
    bus.vld_user2interface = 3'b101;
    #1;
    checks++;
    if (bus.ack_interface2user !== 3'b101) begin
      errors++;
      $display("FAIL reset_ack: got %b want 101", bus.ack_interface2user);
    end
    bus.vld_user2interface = '0;
  endtask

  task automatic test_basic();
    logic [31:0] w [4];
    logic [PB-1:0] exp;
    w[0] = 32'h1111_0001; w[1] = 32'h1111_0002;
    w[2] = 32'h1111_0003; w[3] = 32'h1111_0004;
    do_reset();
    cfg(0, 5'd5, 4'd2, 8'd4);
    bus.bft_ack = 1'b1;
    bus.vld_user2interface = 3'b001;
    set_din(0, 32'hDEADBEEF);
    tick();
    bus.vld_user2interface = '0;
    checks++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      errors++;
      $display("FAIL basic_e0: got %h want 0", bus.dout_leaf_interface2bft);
    end
    tick();
    exp = pkt(5'd5, 4'd2, 7'd0, 32'hDEADBEEF);
    checks++;
    if (bus.dout_leaf_interface2bft !== exp) begin
      errors++;
      $display("FAIL basic_pkt: got %h want %h", bus.dout_leaf_interface2bft, exp);
    end
    tick();
    checks++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      errors++;
      $display("FAIL basic_drain: got %h want 0", bus.dout_leaf_interface2bft);
    end
    // credit is now 3: of four more words only three may issue
    bus.bft_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.vld_user2interface = 3'b001;
      set_din(0, w[k]);
      tick();
    end
    bus.vld_user2interface = '0;
    checks++;
    exp = pkt(5'd5, 4'd2, 7'd1, w[0]);
    if (bus.dout_leaf_interface2bft !== exp) begin
      errors++;
      $display("FAIL basic_hold: got %h want %h", bus.dout_leaf_interface2bft, exp);
    end
    bus.bft_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k < 3) ? pkt(5'd5, 4'd2, 7'(k + 1), w[k]) : '0;
      checks++;
      if (bus.dout_leaf_interface2bft !== exp) begin
        errors++;
        $display("FAIL basic_credit%0d: got %h want %h", k,
                 bus.dout_leaf_interface2bft, exp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [PB-1:0] exp;
    int p;
    int s;
    do_reset();
    for (int i = 0; i < N; i++) cfg(i, 5'(i + 1), 4'(i), 8'd8);
    for (int w = 0; w < 2; w++) begin
      bus.vld_user2interface = 3'b111;
      for (int i = 0; i < N; i++) set_din(i, 32'h1000_0000 + i*16 + w);
      tick();
    end
    bus.vld_user2interface = '0;
    bus.bft_ack = 1'b1;
    for (int k = 0; k < 7; k++) begin
      p = k % 3;
      s = k / 3;
      exp = (k < 6) ? pkt(5'(p + 1), 4'(p), 7'(s), 32'h1000_0000 + p*16 + s)
                    : '0;
      checks++;
      if (bus.dout_leaf_interface2bft !== exp) begin
        errors++;
        $display("FAIL rr_%0d: got %h want %h", k,
                 bus.dout_leaf_interface2bft, exp);
      end
      tick();
    end
  endtask

  task automatic test_credit_stall();
    logic [PB-1:0] exp [8];
    logic [PB-1:0] seen [8];
    logic [31:0] w [5];
    for (int k = 0; k < 5; k++) w[k] = 32'hC0DE_0000 + k;
    do_reset();
    cfg(1, 5'd3, 4'd7, 8'd1);
    bus.bft_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.vld_user2interface = 3'b010;
      set_din(1, w[k]);
      tick();
      seen[k] = bus.dout_leaf_interface2bft;
    end
    bus.vld_user2interface = '0;
    tick();
    seen[3] = bus.dout_leaf_interface2bft;
    exp[0] = '0;
    exp[1] = pkt(5'd3, 4'd7, 7'd0, w[0]);
    exp[2] = '0;
    exp[3] = '0;
    bus.credit_ret_vld = 1'b1;
    bus.credit_ret_port = 4'd1;
    bus.credit_ret_amt = 8'd2;
    tick();
    seen[4] = bus.dout_leaf_interface2bft;
    bus.credit_ret_amt = 8'd0;
    bus.credit_ret_vld = 1'b0;
    tick();
    seen[5] = bus.dout_leaf_interface2bft;
    // issue of w[2] coincides with a return of 1: credit stays at 1
    bus.credit_ret_vld = 1'b1;
    bus.credit_ret_amt = 8'd1;
    tick();
    seen[6] = bus.dout_leaf_interface2bft;
    bus.credit_ret_vld = 1'b0;
    bus.credit_ret_amt = 8'd0;
    exp[4] = '0;
    exp[5] = pkt(5'd3, 4'd7, 7'd1, w[1]);
    exp[6] = pkt(5'd3, 4'd7, 7'd2, w[2]);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (seen[k] !== exp[k]) begin
        errors++;
        $display("FAIL credit_%0d: got %h want %h", k, seen[k], exp[k]);
      end
    end
    for (int k = 3; k < 5; k++) begin
      bus.vld_user2interface = 3'b010;
      set_din(1, w[k]);
      tick();
      seen[k] = bus.dout_leaf_interface2bft;
    end
    bus.vld_user2interface = '0;
    tick();
    seen[5] = bus.dout_leaf_interface2bft;
    tick();
    seen[6] = bus.dout_leaf_interface2bft;
    exp[3] = '0;
    exp[4] = pkt(5'd3, 4'd7, 7'd3, w[3]);
    exp[5] = '0;
    exp[6] = '0;
    for (int k = 3; k < 7; k++) begin
      checks++;
      if (seen[k] !== exp[k]) begin
        errors++;
        $display("FAIL credit_net_%0d: got %h want %h", k, seen[k], exp[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PB-1:0] exp;
    do_reset();
    cfg(0, 5'd1, 4'd1, 8'd8);
    bus.bft_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.vld_user2interface = 3'b001;
      set_din(0, 32'hB0B0_0000 + k);
      #1;
      checks++;
      if (bus.ack_interface2user[0] !== (k < 5)) begin
        errors++;
        $display("FAIL bp_ack%0d: got %b want %b", k,
                 bus.ack_interface2user[0], (k < 5));
      end
      tick();
    end
    bus.vld_user2interface = '0;
    exp = pkt(5'd1, 4'd1, 7'd0, 32'hB0B0_0000);
    tick();
    checks++;
    if (bus.dout_leaf_interface2bft !== exp) begin
      errors++;
      $display("FAIL bp_hold: got %h want %h", bus.dout_leaf_interface2bft, exp);
    end
    bus.bft_ack = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k < 5) ? pkt(5'd1, 4'd1, 7'(k), 32'hB0B0_0000 + k) : '0;
      checks++;
      if (bus.dout_leaf_interface2bft !== exp) begin
        errors++;
        $display("FAIL bp_drain%0d: got %h want %h", k,
                 bus.dout_leaf_interface2bft, exp);
      end
    end
  endtask

  task automatic test_resend();
    logic [PB-1:0] exp;
    do_reset();
    cfg(2, 5'd9, 4'd4, 8'd8);
    for (int k = 0; k < 2; k++) begin
      bus.vld_user2interface = 3'b100;
      set_din(2, 32'hAAAA_0000 + k);
      tick();
    end
    bus.vld_user2interface = 3'b100;
    set_din(2, 32'hAAAA_0002);
    bus.resend = 1'b1;
    bus.bft_ack = 1'b1;
    #1;
    checks++;
    if (bus.dout_leaf_interface2bft !== '0 || bus.ack_interface2user !== 3'b100) begin
      errors++;
      $display("FAIL resend_blank: got %h ack %b want 0 ack 100",
               bus.dout_leaf_interface2bft, bus.ack_interface2user);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.vld_user2interface = '0;
      checks++;
      if (bus.dout_leaf_interface2bft !== '0) begin
        errors++;
        $display("FAIL resend_cyc%0d: got %h want 0", k,
                 bus.dout_leaf_interface2bft);
      end
    end
    bus.resend = 1'b0;
    #1;
    exp = pkt(5'd9, 4'd4, 7'd0, 32'hAAAA_0000);
    checks++;
    if (bus.dout_leaf_interface2bft !== exp) begin
      errors++;
      $display("FAIL resend_back: got %h want %h", bus.dout_leaf_interface2bft, exp);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp = (k < 3) ? pkt(5'd9, 4'd4, 7'(k), 32'hAAAA_0000 + k) : '0;
      checks++;
      if (bus.dout_leaf_interface2bft !== exp) begin
        errors++;
        $display("FAIL resend_next%0d: got %h want %h", k,
                 bus.dout_leaf_interface2bft, exp);
      end
    end
  endtask

  task automatic test_seq_wrap_reset();
    logic [PB-1:0] exp;
    do_reset();
    cfg(0, 5'd1, 4'd0, 8'd255);
    bus.bft_ack = 1'b1;
    for (int t = 1; t <= 131; t++) begin
      bus.vld_user2interface = (t <= 130) ? 3'b001 : 3'b000;
      set_din(0, 32'(t - 1));
      tick();
      if (t - 2 >= 126) begin
        exp = pkt(5'd1, 4'd0, 7'((t - 2) % 128), 32'(t - 2));
        checks++;
        if (bus.dout_leaf_interface2bft !== exp) begin
          errors++;
          $display("FAIL wrap_%0d: got %h want %h", t - 2,
                   bus.dout_leaf_interface2bft, exp);
        end
      end
    end
    bus.vld_user2interface = 3'b001;
    set_din(0, 32'h5555_5555);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.dout_leaf_interface2bft !== '0) begin
      errors++;
      $display("FAIL async_rst: got %h want 0", bus.dout_leaf_interface2bft);
    end
    tick();
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.vld_user2interface = '0;
      checks++;
      if (bus.dout_leaf_interface2bft !== '0) begin
        errors++;
        $display("FAIL rst_credit%0d: got %h want 0", k,
                 bus.dout_leaf_interface2bft);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_credit_stall();
    test_backpressure();
    test_resend();
    test_seq_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
